// File: rtl/mem_stage_if.sv
// Bundle between EXE_reg, the memory stage and the MEM/WB register.
// The memory stage is the slave; the pipeline registers drive it as master.
interface mem_stage_if;
  logic        WB_EN;
  logic        MEM_R;
  logic        MEM_W;
  logic [31:0] ALU_res;
  logic [31:0] val_rm;
  logic [3:0]  dest;
  logic        WB_EN_out;
  logic        MEM_R_out;
  logic [31:0] ALU_res_out;
  logic [3:0]  dest_out;
  logic [31:0] mem_data;
  logic        ready;
  logic        addr_err;

  modport master (
    output WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest,
    input  WB_EN_out, MEM_R_out, ALU_res_out, dest_out, mem_data, ready, addr_err
  );

  modport slave (
    input  WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest,
    output WB_EN_out, MEM_R_out, ALU_res_out, dest_out, mem_data, ready, addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage ARM pipeline: word loads/stores on an internal data
// memory with a fixed multi-cycle latency, freezing the pipeline via ready.
module mem_stage #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);

  localparam int          CW      = $clog2(WAIT_CYCLES) + 1;
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] BASE32  = 32'(BASE_ADDR);
  localparam logic [32:0] LIMIT33 = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            access;
  logic            req;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_data_q;
  logic            addr_err_q;

  assign req      = bus.MEM_R | bus.MEM_W;
  assign idx      = AW'((bus.ALU_res - BASE32) >> 2);
  assign in_range = (bus.ALU_res >= BASE32) && ({1'b0, bus.ALU_res} < LIMIT33);

  assign bus.WB_EN_out   = bus.WB_EN;
  assign bus.MEM_R_out   = bus.MEM_R;
  assign bus.ALU_res_out = bus.ALU_res;
  assign bus.dest_out    = bus.dest;
  assign bus.mem_data    = mem_data_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.ready       = !req || (state == DONE);

  // access marks the edge entering DONE; a dropped request aborts without writing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_nxt = DONE;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(WAIT_CYCLES - 1)) begin
          state_nxt = DONE;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_data_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      addr_err_q <= access && !in_range;
      if (access && bus.MEM_R && !bus.MEM_W)
        mem_data_q <= in_range ? mem[idx] : 32'h0;
    end
  end

  // The array itself is never cleared; reset only blocks an in-flight write
  always_ff @(posedge clk) begin
    if (!rst && access && bus.MEM_W && in_range)
      mem[idx] <= bus.val_rm;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus scoreboard on the 4-cycle
// instance, hand sequences for reset abort, pass-through and the 1-cycle instance.
module tb_mem_stage;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  mem_stage_if bus0 ();
  mem_stage_if bus1 ();

  mem_stage #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_stage #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic wb, input logic [3:0] dst);
    @(posedge clk);
    #1;
    bus0.MEM_R   = rd;
    bus0.MEM_W   = wr;
    bus0.ALU_res = addr;
    bus0.val_rm  = data;
    bus0.WB_EN   = wb;
    bus0.dest    = dst;
  endtask

  // Issue one memory op on dut0 and count the freeze; the monitor checks the result
  task automatic memOp(input vec_t v);
    exp_t e;
    int   freeze = 0;
    bit   done   = 0;
    e.data = v.expData;
    e.err  = v.expErr;
    sbq.push_back(e);
    applyStimulus(v.rd, v.wr, v.addr, v.data, 1'b0, 4'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus0.ready === 1'b1) begin
        done = 1;
        break;
      end
      freeze++;
      checkOutput("addr_err_while_frozen", {31'b0, bus0.addr_err}, 32'd0);
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL op_timeout: addr 0x%08h never completed within 20 cycles", v.addr);
    end else begin
      checkOutput("freeze_len", 32'(freeze), 32'd4);
    end
  endtask

  // Scoreboard: a DONE cycle is the only cycle with a request and ready high
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && (bus0.MEM_R === 1'b1 || bus0.MEM_W === 1'b1) && bus0.ready === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_unexpected_done: got DONE at addr 0x%08h, want no completion", bus0.ALU_res);
      end else begin
        e = sbq.pop_front();
        checkOutput("sb_mem_data", bus0.mem_data, e.data);
        checkOutput("sb_addr_err", {31'b0, bus0.addr_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd1028, 32'h11,       32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h11,       1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'd1031, 32'h0,        32'h11,       1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'd1276, 32'h63636363, 32'h11,       1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'd1280, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'd1280, 32'hBAD0BAD0, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'd1020, 32'hBAD1BAD1, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'h63636363, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'd1036, 32'h99,       32'h63636363, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'd1036, 32'h0,        32'h99,       1'b0};

    rst = 1'b1;
    bus0.MEM_R = 1'b0; bus0.MEM_W = 1'b0; bus0.ALU_res = '0; bus0.val_rm = '0;
    bus0.WB_EN = 1'b0; bus0.dest = '0;
    bus1.MEM_R = 1'b0; bus1.MEM_W = 1'b0; bus1.ALU_res = '0; bus1.val_rm = '0;
    bus1.WB_EN = 1'b0; bus1.dest = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready",    {31'b0, bus0.ready},    32'd1);
    checkOutput("reset_mem_data", bus0.mem_data,          32'h0);
    checkOutput("reset_addr_err", {31'b0, bus0.addr_err}, 32'd0);
    checkOutput("reset_dut1_mem_data", bus1.mem_data,     32'h0);

    foreach (vecs[i]) memOp(vecs[i]);

    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      logic [3:0]  d;
      logic        wb;
      a  = 32'h1234 + 32'(i * 16);
      d  = 4'(7 + i);
      wb = (i != 1);
      applyStimulus(1'b0, 1'b0, a, 32'hFFFF0000, wb, d);
      #1;
      checkOutput("pass_ready",   {31'b0, bus0.ready},     32'd1);
      checkOutput("pass_wb_en",   {31'b0, bus0.WB_EN_out}, {31'b0, wb});
      checkOutput("pass_mem_r",   {31'b0, bus0.MEM_R_out}, 32'd0);
      checkOutput("pass_alu_res", bus0.ALU_res_out,        a);
      checkOutput("pass_dest",    {28'b0, bus0.dest_out},  {28'b0, d});
      @(negedge clk);
      checkOutput("pass_mem_data_hold", bus0.mem_data, 32'h99);
    end

    memOp('{1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h99, 1'b0});
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h55, 1'b0, 4'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.MEM_W = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready",    {31'b0, bus0.ready},    32'd1);
    checkOutput("abort_mem_data", bus0.mem_data,          32'h0);
    checkOutput("abort_addr_err", {31'b0, bus0.addr_err}, 32'd0);
    memOp('{1'b1, 1'b0, 32'd1032, 32'h0, 32'hA5A5A5A5, 1'b0});
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);

    @(posedge clk);
    #1;
    bus1.MEM_R = 1'b1; bus1.MEM_W = 1'b1; bus1.ALU_res = 32'd1036; bus1.val_rm = 32'h99;
    @(negedge clk);
    checkOutput("w1_rw_frozen", {31'b0, bus1.ready}, 32'd0);
    @(negedge clk);
    checkOutput("w1_rw_done_ready", {31'b0, bus1.ready},    32'd1);
    checkOutput("w1_rw_mem_data",   bus1.mem_data,          32'h0);
    checkOutput("w1_rw_addr_err",   {31'b0, bus1.addr_err}, 32'd0);
    @(posedge clk);
    #1 bus1.MEM_W = 1'b0;
    @(negedge clk);
    checkOutput("w1_ld_frozen", {31'b0, bus1.ready}, 32'd0);
    @(negedge clk);
    checkOutput("w1_ld_done_ready", {31'b0, bus1.ready}, 32'd1);
    checkOutput("w1_ld_mem_data",   bus1.mem_data,       32'h99);
    @(posedge clk);
    #1 bus1.MEM_R = 1'b0;
    @(negedge clk);
    checkOutput("w1_idle_ready",    {31'b0, bus1.ready},    32'd1);
    checkOutput("w1_idle_mem_data", bus1.mem_data,          32'h99);

    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
